// File: rtl/data_bus.sv
// Data-side bus for the core mem stage: zero-wait RAM plus the
// machine timer (mtime/mtimecmp) with a registered interrupt level.
module data_bus #(
    parameter int RAM_DEPTH = 4096,
    parameter int TICK_DIV  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ram_request_i,
    input  logic        ram_we_i,
    input  logic [3:0]  ram_op_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_wdata_i,
    output logic [31:0] ram_rdata_o,
    output logic        bus_err_o,
    output logic        timer_irq_o
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [29:0] CMP_LO = 30'h0080_1000;
    localparam logic [29:0] CMP_HI = 30'h0080_1001;
    localparam logic [29:0] MT_LO  = 30'h0080_2FFE;
    localparam logic [29:0] MT_HI  = 30'h0080_2FFF;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    logic [31:0]   mem [RAM_DEPTH];
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic [PW-1:0] presc;

    size_e       size;
    logic        sext;
    logic        op_ok;
    logic        op_store;
    logic [1:0]  lane;
    logic [29:0] waddr;
    logic [AW-1:0] idx;
    logic        is_ram;
    logic        is_cmp_lo;
    logic        is_cmp_hi;
    logic        is_mt_lo;
    logic        is_mt_hi;
    logic        is_tmr;
    logic        misal;
    logic        err;
    logic        ld;
    logic        st;
    logic        tick;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [3:0]  be;
    logic [31:0] wlane;

    always_comb begin
        size     = SZ_W;
        sext     = 1'b0;
        op_ok    = 1'b1;
        op_store = 1'b0;
        case (ram_op_i)
            4'b0000: begin size = SZ_B; sext = 1'b1; end
            4'b0001: begin size = SZ_H; sext = 1'b1; end
            4'b0010: size = SZ_W;
            4'b0100: size = SZ_B;
            4'b0101: size = SZ_H;
            4'b1000: begin size = SZ_B; op_store = 1'b1; end
            4'b1001: begin size = SZ_H; op_store = 1'b1; end
            4'b1010: begin size = SZ_W; op_store = 1'b1; end
            default: op_ok = 1'b0;
        endcase
    end

    assign lane      = ram_addr_i[1:0];
    assign waddr     = ram_addr_i[31:2];
    assign idx       = ram_addr_i[AW+1:2];
    assign is_ram    = (ram_addr_i >> (AW + 2)) == '0;
    assign is_cmp_lo = waddr == CMP_LO;
    assign is_cmp_hi = waddr == CMP_HI;
    assign is_mt_lo  = waddr == MT_LO;
    assign is_mt_hi  = waddr == MT_HI;
    assign is_tmr    = is_cmp_lo | is_cmp_hi | is_mt_lo | is_mt_hi;

    assign misal = ((size == SZ_H) && lane[0]) ||
                   ((size == SZ_W) && (lane != 2'b00));

    // A store opcode paired with a load strobe (or vice versa) is undefined.
    always_comb begin
        err = 1'b0;
        if (ram_request_i) begin
            err = !op_ok || (op_store != ram_we_i) || misal ||
                  !(is_ram || is_tmr) ||
                  (is_tmr && ram_we_i && (size != SZ_W));
        end
    end

    assign ld = ram_request_i && !err && !ram_we_i;
    assign st = ram_request_i && !err && ram_we_i;

    always_comb begin
        rd_word = '0;
        if (is_ram)         rd_word = mem[idx];
        else if (is_cmp_lo) rd_word = mtimecmp[31:0];
        else if (is_cmp_hi) rd_word = mtimecmp[63:32];
        else if (is_mt_lo)  rd_word = mtime[31:0];
        else if (is_mt_hi)  rd_word = mtime[63:32];
    end

    assign rd_byte = 8'(rd_word >> {lane, 3'b000});
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ram_rdata_o = '0;
        if (ld) begin
            case (size)
                SZ_B:    ram_rdata_o = {{24{sext & rd_byte[7]}}, rd_byte};
                SZ_H:    ram_rdata_o = {{16{sext & rd_half[15]}}, rd_half};
                default: ram_rdata_o = rd_word;
            endcase
        end
    end

    always_comb begin
        be    = 4'b1111;
        wlane = ram_wdata_i;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << lane;
                wlane = {4{ram_wdata_i[7:0]}};
            end
            SZ_H: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wlane = {2{ram_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // RAM has no reset; stores are simply blocked while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_i && st && is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    assign tick = presc == PW'(TICK_DIV - 1);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            presc       <= '0;
            timer_irq_o <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            timer_irq_o <= mtime >= mtimecmp;
            bus_err_o   <= err;
            presc       <= tick ? '0 : presc + 1'b1;
            if (st && is_mt_lo)      mtime[31:0]  <= ram_wdata_i;
            else if (st && is_mt_hi) mtime[63:32] <= ram_wdata_i;
            else if (tick)           mtime        <= mtime + 64'd1;
            if (st && is_cmp_lo) mtimecmp[31:0]  <= ram_wdata_i;
            if (st && is_cmp_hi) mtimecmp[63:32] <= ram_wdata_i;
        end
    end

endmodule

// File: tb/tb_data_bus.sv
// Randomized bench for data_bus against a byte-level reference model
// of memory and timer, plus directed scenarios.
module tb_data_bus;

    localparam int DEPTH = 4096;
    localparam int TDIV  = 1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ram_request_i;
    logic        ram_we_i;
    logic [3:0]  ram_op_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_wdata_i;
    logic [31:0] ram_rdata_o;
    logic        bus_err_o;
    logic        timer_irq_o;

    data_bus #(.RAM_DEPTH(DEPTH), .TICK_DIV(TDIV)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .ram_request_i(ram_request_i),
        .ram_we_i(ram_we_i),
        .ram_op_i(ram_op_i),
        .ram_addr_i(ram_addr_i),
        .ram_wdata_i(ram_wdata_i),
        .ram_rdata_o(ram_rdata_o),
        .bus_err_o(bus_err_o),
        .timer_irq_o(timer_irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem_m [256];
    logic [63:0] mt_m;
    logic [63:0] cmp_m;
    int          pre_m;
    logic        irq_m;
    logic        err_m;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [3:0] op);
        logic [1:0] s;
        s = op[1:0];
        if (s == 2'd0) return 1;
        if (s == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit is_ram_a(input logic [31:0] a);
        return a < 32'(4 * DEPTH);
    endfunction

    function automatic bit is_tmr_a(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return w == 32'h0200_4000 || w == 32'h0200_4004 ||
               w == 32'h0200_BFF8 || w == 32'h0200_BFFC;
    endfunction

    function automatic bit m_err(input bit we, input logic [3:0] op,
                                 input logic [31:0] a);
        int nb;
        if (!(op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10}))
            return 1;
        if (we != op[3]) return 1;
        nb = nbytes(op);
        if ((a % nb) != 0) return 1;
        if (!is_ram_a(a) && !is_tmr_a(a)) return 1;
        if (is_tmr_a(a) && we && nb != 4) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        logic [31:0] w;
        int b;
        w = a & 32'hFFFF_FFFC;
        if (w == 32'h0200_4000) return cmp_m[31:0];
        if (w == 32'h0200_4004) return cmp_m[63:32];
        if (w == 32'h0200_BFF8) return mt_m[31:0];
        if (w == 32'h0200_BFFC) return mt_m[63:32];
        b = int'(w % 256);
        return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
    endfunction

    function automatic logic [31:0] m_rdata(input bit rq, input bit we,
                                            input logic [3:0] op,
                                            input logic [31:0] a);
        logic [31:0] v;
        int nb;
        if (!rq || we || m_err(we, op, a)) return 32'd0;
        nb = nbytes(op);
        v = m_word(a) >> ((a % 4) * 8);
        if (nb == 1) begin
            v = v & 32'hFF;
            if (!op[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (nb == 2) begin
            v = v & 32'hFFFF;
            if (!op[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic m_edge(input bit rq, input bit we, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit rst_n);
        bit e;
        bit wr_mt;
        logic [31:0] w;
        if (!rst_n) begin
            mt_m  = 64'd0;
            cmp_m = 64'hFFFF_FFFF_FFFF_FFFF;
            pre_m = 0;
            irq_m = 1'b0;
            err_m = 1'b0;
            return;
        end
        e     = rq && m_err(we, op, a);
        irq_m = mt_m >= cmp_m;
        err_m = e;
        wr_mt = 1'b0;
        w     = a & 32'hFFFF_FFFC;
        if (rq && we && !e) begin
            if (is_ram_a(a)) begin
                for (int k = 0; k < nbytes(op); k++)
                    mem_m[int'((a + k) % 256)] = 8'(wd >> (8 * k));
            end else if (w == 32'h0200_4000) cmp_m[31:0] = wd;
            else if (w == 32'h0200_4004) cmp_m[63:32] = wd;
            else if (w == 32'h0200_BFF8) begin
                mt_m[31:0] = wd;
                wr_mt = 1'b1;
            end else if (w == 32'h0200_BFFC) begin
                mt_m[63:32] = wd;
                wr_mt = 1'b1;
            end
        end
        if (pre_m == TDIV - 1) begin
            pre_m = 0;
            if (!wr_mt) mt_m = mt_m + 64'd1;
        end else begin
            pre_m = pre_m + 1;
        end
    endtask

    // One bus cycle: starts 1 time unit after a rising edge.
    task automatic cyc(input bit rq, input bit we, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit rst_n);
        logic [31:0] exp;
        rst_i         = rst_n;
        ram_request_i = rq;
        ram_we_i      = we;
        ram_op_i      = op;
        ram_addr_i    = a;
        ram_wdata_i   = wd;
        exp = m_rdata(rq, we, op, a);
        #4;
        last_rd = ram_rdata_o;
        check("rdata", 64'(last_rd), 64'(exp));
        @(posedge clk_i);
        m_edge(rq, we, op, a, wd, rst_n);
        #1;
        check("bus_err", 64'(bus_err_o), 64'(err_m));
        check("irq", 64'(timer_irq_o), 64'(irq_m));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 32'd0, 32'd0, 1);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        cyc(1, 1, 4'b1010, a, d, 1);
    endtask

    task automatic ld(input logic [3:0] op, input logic [31:0] a);
        cyc(1, 0, op, a, $urandom, 1);
    endtask

    localparam logic [31:0] T_ADDR [4] = '{
        32'h0200_4000, 32'h0200_4004, 32'h0200_BFF8, 32'h0200_BFFC
    };
    localparam logic [3:0] OPS [8] = '{
        4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10
    };

    initial begin
        @(posedge clk_i);
        #1;
        cyc(0, 0, 4'd0, 32'd0, 32'd0, 0);
        cyc(1, 1, 4'd10, 32'd0, 32'hDEAD_BEEF, 0);
        check("rst_mtime_lo", 64'(dut.mtime), 64'd0);
        for (int i = 0; i < 64; i++) sw(32'(i * 4), $urandom);

        sw(32'h10, 32'h8000_00F1);
        ld(4'd0, 32'h10); check("lb", 64'(last_rd), 64'hFFFF_FFF1);
        ld(4'd4, 32'h10); check("lbu", 64'(last_rd), 64'h0000_00F1);
        ld(4'd1, 32'h10); check("lh", 64'(last_rd), 64'h0000_00F1);
        ld(4'd5, 32'h10); check("lhu", 64'(last_rd), 64'h0000_00F1);
        ld(4'd2, 32'h10); check("lw", 64'(last_rd), 64'h8000_00F1);

        sw(32'h20, 32'h1122_3344);
        cyc(1, 1, 4'b1000, 32'h22, 32'h0000_00AA, 1);
        cyc(1, 1, 4'b1001, 32'h20, 32'h0000_BBCC, 1);
        ld(4'd2, 32'h20); check("merge", 64'(last_rd), 64'h11AA_BBCC);

        cyc(1, 1, 4'b1001, 32'h21, 32'h0000_5555, 1);
        check("err_sh", 64'(bus_err_o), 64'd1);
        ld(4'd2, 32'h22);
        check("err_lw", 64'(bus_err_o), 64'd1);
        check("err_lw_rd", 64'(last_rd), 64'd0);
        ld(4'd2, 32'h1000_0000);
        check("err_unm", 64'(bus_err_o), 64'd1);
        ld(4'd2, 32'h20); check("ram_keep", 64'(last_rd), 64'h11AA_BBCC);
        check("err_clr", 64'(bus_err_o), 64'd0);

        cyc(0, 0, 4'd0, 32'd0, 32'd0, 0);
        sw(32'h0200_4004, 32'd0);
        sw(32'h0200_4000, 32'd5);
        idle(8);
        check("irq_rise", 64'(timer_irq_o), 64'd1);
        sw(32'h0200_4000, 32'hFFFF_FFFF);
        idle(1);
        check("irq_fall", 64'(timer_irq_o), 64'd0);

        sw(32'h0200_BFFC, 32'hFFFF_FFFF);
        sw(32'h0200_BFF8, 32'hFFFF_FFFE);
        idle(2);
        ld(4'd2, 32'h0200_BFF8); check("wrap_lo", 64'(last_rd), 64'd0);
        ld(4'd2, 32'h0200_BFFC); check("wrap_hi", 64'(last_rd), 64'd0);

        idle(3);
        cyc(1, 1, 4'd10, 32'h0200_BFF8, 32'h1234_5678, 0);
        ld(4'd2, 32'h0200_BFF8); check("rst_mt", 64'(last_rd), 64'd0);
        check("rst_irq", 64'(timer_irq_o), 64'd0);
        ld(4'd2, 32'h20); check("ram_rst", 64'(last_rd), 64'h11AA_BBCC);

        for (int n = 0; n < 3000; n++) begin
            int cls;
            logic [3:0] op;
            logic [31:0] a;
            bit we;
            cls = int'($urandom_range(0, 9));
            if ($urandom_range(0, 9) < 9) begin
                op = OPS[$urandom_range(0, 7)];
                we = op[3];
            end else begin
                op = 4'($urandom);
                we = 1'($urandom);
            end
            if (cls < 6) a = 32'($urandom_range(0, 255));
            else if (cls < 8)
                a = T_ADDR[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
            else a = 32'h1000_0000 + ($urandom & 32'hFFFF);
            if (cls == 9)
                cyc(0, 1'($urandom), op, a, $urandom, 1);
            else
                cyc(1, we, op, a, $urandom, $urandom_range(0, 199) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_bus.md
DATA_BUS -- requirements
Module: data_bus

Interface
REQ-001 SHALL have parameter RAM_DEPTH, 4096, number of 32-bit RAM words (power of two).
REQ-002 SHALL have parameter TICK_DIV, 1, clk_i cycles per mtime increment (>=1).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ram_request_i  input  1  access valid this cycle (from core mem stage).
REQ-006 SHALL have port ram_we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port ram_op_i  input  4  access type: 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW.
REQ-008 SHALL have port ram_addr_i  input  32  byte address.
REQ-009 SHALL have port ram_wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port ram_rdata_o  output  32  load data, extended per ram_op_i.
REQ-011 SHALL have port bus_err_o  output  1  registered one-cycle pulse on decode/alignment error.
REQ-012 SHALL have port timer_irq_o  output  1  registered machine timer interrupt level.

Function
REQ-013 SHALL decode: RAM at 0x0000_0000 up to 4*RAM_DEPTH-1; mtimecmp lo/hi at 0x0200_4000/0x0200_4004; mtime lo/hi at 0x0200_BFF8/0x0200_BFFC; all else unmapped.
REQ-014 SHALL return load data combinationally in the same cycle as ram_request_i (zero wait states); no stall output exists.
REQ-015 SHALL select byte lane by addr[1:0] and half lane by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-016 SHALL drive ram_rdata_o = 0 when ram_request_i=0, ram_we_i=1, access unmapped, or misaligned.
REQ-017 SHALL commit stores at the clock edge of the request cycle, updating only addressed byte lanes; other lanes of the word unchanged.
REQ-018 SHALL treat LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 as misaligned: no state change, bus_err_o=1 next cycle.
REQ-019 SHALL treat unmapped access or undefined ram_op_i as error: no state change, bus_err_o=1 next cycle.
REQ-020 SHALL accept only SW to timer registers; SB/SH to timer addresses are errors per REQ-019; LB/LH/LBU/LHU of timer registers are permitted.
REQ-021 SHALL hold a prescaler counter 0..TICK_DIV-1; mtime (64-bit) increments by 1 on the edge where the prescaler equals TICK_DIV-1, prescaler then returns to 0.
REQ-022 SHALL wrap mtime from 0xFFFF_FFFF_FFFF_FFFF to 0 without error.
REQ-023 SHALL give a software write to mtime lo or hi priority over the increment in that cycle: written half takes wdata, other half holds, no increment that cycle; prescaler continues counting.
REQ-024 SHALL write mtimecmp lo/hi halves independently via SW.
REQ-025 SHALL register timer_irq_o each cycle as (mtime >= mtimecmp), unsigned 64-bit, using pre-edge register values; a write lowering/raising mtimecmp is reflected one cycle after the following edge.
REQ-026 SHALL read mtime/mtimecmp halves as current register contents (pre-edge values).
REQ-027 SHALL not modify RAM or timer when ram_request_i=0 regardless of other inputs.

Reset
REQ-028 SHALL on rst_i=0 at an edge set mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, prescaler=0, timer_irq_o=0, bus_err_o=0.
REQ-029 SHALL ignore stores presented in a reset cycle; reset overrides any simultaneous write or increment.
REQ-030 SHALL NOT initialise RAM contents on reset; RAM retains data across reset.

Verification
REQ-031 SW 0x8000_00F1 to 0x10, then LB/LBU/LH/LHU/LW at 0x10 -> 0xFFFF_FFF1, 0x0000_00F1, 0x0000_00F1, 0x0000_00F1, 0x8000_00F1.
REQ-032 SW 0x1122_3344 to 0x20, SB 0xAA to 0x22, SH 0xBBCC to 0x20 -> LW 0x20 returns 0x11AA_BBCC.
REQ-033 SH at 0x21, LW at 0x22, LW at 0x1000_0000 -> bus_err_o pulses 1 each following cycle, RAM unchanged, rdata 0.
REQ-034 TICK_DIV=1: after reset write mtimecmp hi=0, lo=5 -> timer_irq_o rises when mtime reaches 5 (one cycle later); write mtimecmp lo=0xFFFF_FFFF -> irq falls.
REQ-035 Write mtime hi=0xFFFF_FFFF, lo=0xFFFF_FFFE -> two increments later reads mtime lo=0, hi=0; irq follows compare.
REQ-036 Assert rst_i=0 mid-count with simultaneous SW to mtime lo -> next cycle mtime=0, irq=0; previously written RAM word still reads back.
